vending_machine_gen: RTL and testbench

VENDING_MACHINE_GEN -- requirements
Module: vending_machine_gen

---
 rtl/vending_machine_gen.sv | 182 ++++++++++++++++++
 tb/tb_vending_machine_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_gen.sv
// vending_machine_gen -- parameterized coin-operated vending controller.
//
// Flow: IDLE -> (sel) COLLECT -> (credit >= price) VEND -> CHANGE -> IDLE.
// Coins are accepted in IDLE/COLLECT and added at the clock edge. VEND pulses
// deliver for one cycle and deducts the price. CHANGE pays out the remainder
// one coin at a time (largest 5/2/1 that fits), handshaked by change_ack.
//
// Optional feature: define VM_CANCEL_EN to enable the cancel/refund input.
// Without it the cancel port exists but has no effect.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   sel          product buttons, lowest set index wins (IDLE only)
//   coin         one-cycle coin strobe, one-hot: bit0=1, bit1=2, bit2=5
//   cancel       refund request (VM_CANCEL_EN only)
//   change_ack   hopper accepted the current change_coin
//   product      latched one-hot selection
//   deliver      one-cycle vend pulse
//   change_coin  one-hot change coin request, 0 = none
//   credit       registered credit
//   coin_reject  one-cycle pulse (cycle after the coin) when a coin is refused
//   busy         high in VEND and CHANGE
module vending_machine_gen #(
  parameter int                           N_PROD     = 4,
  parameter int                           CREDIT_W   = 8,
  parameter logic [N_PROD*CREDIT_W-1:0]   PRICES     = {8'd7, 8'd5, 8'd3, 8'd2},
  parameter int                           MAX_CREDIT = 99
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_PROD-1:0]   sel,
  input  logic [2:0]          coin,
  input  logic                cancel,
  input  logic                change_ack,
  output logic [N_PROD-1:0]   product,
  output logic                deliver,
  output logic [2:0]          change_coin,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [N_PROD-1:0]   product_q, product_d;
  logic                reject_q, reject_d;

  logic [N_PROD-1:0]   sel_first;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W-1:0] coin_val, coin_sum;
  logic                coin_ok, coin_fits;
  logic [CREDIT_W-1:0] chg_val;
  logic [2:0]          chg_code;
  logic [CREDIT_W-1:0] vend_rem, chg_rem;
  logic                cancel_req;

`ifdef VM_CANCEL_EN
  assign cancel_req = cancel;
`else
  logic unused_cancel;
  assign cancel_req    = 1'b0;
  assign unused_cancel = cancel;
`endif

  // Lowest-index button wins: scan high to low so the last hit is the lowest.
  always_comb begin
    sel_first = '0;
    for (int i = N_PROD - 1; i >= 0; i--)
      if (sel[i]) begin
        sel_first    = '0;
        sel_first[i] = 1'b1;
      end
  end

  always_comb begin
    price = '0;
    for (int i = 0; i < N_PROD; i++)
      if (product_q[i]) price = PRICES[i*CREDIT_W +: CREDIT_W];
  end

  always_comb begin
    coin_val = '0;
    coin_ok  = 1'b1;
    case (coin)
      3'b001:  coin_val = CREDIT_W'(1);
      3'b010:  coin_val = CREDIT_W'(2);
      3'b100:  coin_val = CREDIT_W'(5);
      default: coin_ok  = 1'b0;
    endcase
  end

  assign coin_sum  = credit_q + coin_val;
  assign coin_fits = (coin_sum <= CREDIT_W'(MAX_CREDIT));

  // Greedy change: largest denomination not exceeding the remaining credit.
  always_comb begin
    chg_val  = '0;
    chg_code = 3'b000;
    if (credit_q >= CREDIT_W'(5)) begin
      chg_val  = CREDIT_W'(5);
      chg_code = 3'b100;
    end else if (credit_q >= CREDIT_W'(2)) begin
      chg_val  = CREDIT_W'(2);
      chg_code = 3'b010;
    end else if (credit_q != '0) begin
      chg_val  = CREDIT_W'(1);
      chg_code = 3'b001;
    end
  end

  assign vend_rem = credit_q - price;
  assign chg_rem  = credit_q - chg_val;

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    product_d = product_q;
    reject_d  = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (cancel_req) begin
          // Cancel outranks sel and coin; a same-cycle coin is refused.
          product_d = '0;
          reject_d  = |coin;
          state_d   = (credit_q != '0) ? CHANGE : IDLE;
        end else begin
          if (coin != 3'b000) begin
            if (coin_ok && coin_fits) credit_d = coin_sum;
            else                      reject_d = 1'b1;
          end
          if (state_q == IDLE && (|sel)) begin
            product_d = sel_first;
            state_d   = COLLECT;
          end
          // Uses registered credit only; a coin arriving now counts next time.
          if (state_q == COLLECT && credit_q >= price) state_d = VEND;
        end
      end
      VEND: begin
        reject_d  = |coin;
        credit_d  = vend_rem;
        product_d = '0;
        state_d   = (vend_rem != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_d = |coin;
        if (credit_q == '0) begin
          state_d = IDLE;
        end else if (change_ack) begin
          credit_d = chg_rem;
          if (chg_rem == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      credit_q  <= '0;
      product_q <= '0;
      reject_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      product_q <= product_d;
      reject_q  <= reject_d;
    end
  end

  assign product     = product_q;
  assign credit      = credit_q;
  assign coin_reject = reject_q;
  assign deliver     = (state_q == VEND);
  assign busy        = (state_q == VEND) || (state_q == CHANGE);
  assign change_coin = (state_q == CHANGE) ? chg_code : 3'b000;

endmodule

// File: tb/tb_vending_machine_gen.sv
// Directed testbench for vending_machine_gen (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_vending_machine_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sel;
  logic [2:0] coin;
  logic       cancel;
  logic       change_ack;
  logic [3:0] product;
  logic       deliver;
  logic [2:0] change_coin;
  logic [7:0] credit;
  logic       coin_reject;
  logic       busy;

  int errors = 0;
  int checks = 0;

  vending_machine_gen dut (
    .clk(clk), .reset(reset), .sel(sel), .coin(coin), .cancel(cancel),
    .change_ack(change_ack), .product(product), .deliver(deliver),
    .change_coin(change_coin), .credit(credit), .coin_reject(coin_reject),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; sel = '0; coin = '0; cancel = 1'b0; change_ack = 1'b0;
    #2 reset = 1'b0;
    #10;
    checks++; if (credit !== 8'd0) begin errors++; $display("FAIL reset_credit: got %0d want 0", credit); end
    checks++; if ({product, deliver, change_coin, coin_reject, busy} !== 10'd0) begin
      errors++; $display("FAIL reset_outputs: product=%b deliver=%b change_coin=%b reject=%b busy=%b want all 0",
                         product, deliver, change_coin, coin_reject, busy);
    end
    #1 reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || credit !== 8'd0) begin errors++; $display("FAIL reset_release: busy=%b credit=%0d want 0/0", busy, credit); end
  endtask

  task automatic test_basic();
    sel = 4'b0001; coin = 3'b010;
    tick();
    sel = '0; coin = '0;
    checks++; if (credit !== 8'd2) begin errors++; $display("FAIL basic_credit: got %0d want 2", credit); end
    checks++; if (product !== 4'b0001) begin errors++; $display("FAIL basic_product: got %b want 0001", product); end
    checks++; if (deliver !== 1'b0 || busy !== 1'b0 || change_coin !== 3'b000) begin
      errors++; $display("FAIL basic_collect: deliver=%b busy=%b change_coin=%b want 0/0/000", deliver, busy, change_coin);
    end
    tick();
    checks++; if (deliver !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_vend: deliver=%b busy=%b want 1/1", deliver, busy); end
    checks++; if (change_coin !== 3'b000) begin errors++; $display("FAIL basic_vend_change: got %b want 000", change_coin); end
    tick();
    checks++; if (deliver !== 1'b0 || credit !== 8'd0 || product !== 4'b0000 || busy !== 1'b0 || change_coin !== 3'b000) begin
      errors++; $display("FAIL basic_idle: deliver=%b credit=%0d product=%b busy=%b change_coin=%b want 0/0/0000/0/000",
                         deliver, credit, product, busy, change_coin);
    end
  endtask

  task automatic test_vend_reject();
    sel = 4'b0100; coin = 3'b100;
    tick();
    sel = '0; coin = '0;
    checks++; if (credit !== 8'd5 || product !== 4'b0100) begin errors++; $display("FAIL p5_collect: credit=%0d product=%b want 5/0100", credit, product); end
    tick();
    checks++; if (deliver !== 1'b1) begin errors++; $display("FAIL p5_deliver: got %b want 1", deliver); end
    coin = 3'b010;
    tick();
    coin = '0;
    checks++; if (coin_reject !== 1'b1) begin errors++; $display("FAIL p5_vend_reject: got %b want 1", coin_reject); end
    checks++; if (credit !== 8'd0 || change_coin !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL p5_no_change: credit=%0d change_coin=%b busy=%b want 0/000/0", credit, change_coin, busy);
    end
    tick();
    checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL p5_reject_pulse: got %b want 0", coin_reject); end
  endtask

  task automatic test_change();
    sel = 4'b0010; coin = 3'b100;
    tick();
    sel = '0;
    checks++; if (credit !== 8'd5) begin errors++; $display("FAIL chg_first_coin: got %0d want 5", credit); end
    tick();
    coin = '0;
    checks++; if (deliver !== 1'b1 || credit !== 8'd10) begin errors++; $display("FAIL chg_vend: deliver=%b credit=%0d want 1/10", deliver, credit); end
    tick();
    checks++; if (credit !== 8'd7 || change_coin !== 3'b100 || busy !== 1'b1 || product !== 4'b0000) begin
      errors++; $display("FAIL chg_enter: credit=%0d change_coin=%b busy=%b product=%b want 7/100/1/0000",
                         credit, change_coin, busy, product);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (credit !== 8'd7 || change_coin !== 3'b100) begin
        errors++; $display("FAIL chg_hold%0d: credit=%0d change_coin=%b want 7/100", i, credit, change_coin);
      end
    end
    change_ack = 1'b1;
    tick();
    checks++; if (credit !== 8'd2 || change_coin !== 3'b010) begin errors++; $display("FAIL chg_ack1: credit=%0d change_coin=%b want 2/010", credit, change_coin); end
    tick();
    change_ack = 1'b0;
    checks++; if (credit !== 8'd0 || change_coin !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL chg_done: credit=%0d change_coin=%b busy=%b want 0/000/0", credit, change_coin, busy);
    end
  endtask

  task automatic test_bad_coin();
    sel = 4'b1000; coin = 3'b001;
    tick();
    sel = '0; coin = 3'b011;
    tick();
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd1) begin errors++; $display("FAIL bad_coin: reject=%b credit=%0d want 1/1", coin_reject, credit); end
    sel = 4'b0001; coin = 3'b100;
    tick();
    checks++; if (credit !== 8'd6 || coin_reject !== 1'b0) begin errors++; $display("FAIL bad_next_coin: credit=%0d reject=%b want 6/0", credit, coin_reject); end
    checks++; if (product !== 4'b1000) begin errors++; $display("FAIL sel_ignored: product=%b want 1000", product); end
    sel = '0; coin = 3'b001;
    tick();
    coin = '0;
    checks++; if (credit !== 8'd7 || deliver !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL p7_collect: credit=%0d deliver=%b busy=%b want 7/0/0", credit, deliver, busy);
    end
    tick();
    checks++; if (deliver !== 1'b1) begin errors++; $display("FAIL p7_deliver: got %b want 1", deliver); end
    tick();
    checks++; if (credit !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL p7_idle: credit=%0d busy=%b want 0/0", credit, busy); end
  endtask

  task automatic test_max_credit();
    coin = 3'b100;
    for (int i = 0; i < 19; i++) tick();
    coin = 3'b010;
    tick();
    tick();
    checks++; if (credit !== 8'd99 || coin_reject !== 1'b0) begin errors++; $display("FAIL max_fill: credit=%0d reject=%b want 99/0", credit, coin_reject); end
    coin = 3'b001;
    tick();
    coin = '0;
    checks++; if (credit !== 8'd99 || coin_reject !== 1'b1) begin errors++; $display("FAIL max_over: credit=%0d reject=%b want 99/1", credit, coin_reject); end
    reset = 1'b0;
    #1;
    checks++; if (credit !== 8'd0) begin errors++; $display("FAIL max_reset: credit=%0d want 0", credit); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_cancel();
`ifdef VM_CANCEL_EN
    sel = 4'b0100; coin = 3'b010;
    tick();
    sel = '0;
    tick();
    checks++; if (credit !== 8'd4 || busy !== 1'b0) begin errors++; $display("FAIL cancel_credit: credit=%0d busy=%b want 4/0", credit, busy); end
    cancel = 1'b1; coin = 3'b001;
    tick();
    cancel = 1'b0; coin = '0;
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd4) begin errors++; $display("FAIL cancel_reject: reject=%b credit=%0d want 1/4", coin_reject, credit); end
    checks++; if (product !== 4'b0000 || change_coin !== 3'b010 || busy !== 1'b1) begin
      errors++; $display("FAIL cancel_change: product=%b change_coin=%b busy=%b want 0000/010/1", product, change_coin, busy);
    end
    change_ack = 1'b1;
    tick();
    checks++; if (credit !== 8'd2 || change_coin !== 3'b010 || deliver !== 1'b0) begin
      errors++; $display("FAIL cancel_ack1: credit=%0d change_coin=%b deliver=%b want 2/010/0", credit, change_coin, deliver);
    end
    tick();
    change_ack = 1'b0;
    checks++; if (credit !== 8'd0 || change_coin !== 3'b000 || busy !== 1'b0 || deliver !== 1'b0) begin
      errors++; $display("FAIL cancel_done: credit=%0d change_coin=%b busy=%b deliver=%b want 0/000/0/0", credit, change_coin, busy, deliver);
    end
`else
    sel = 4'b0100; coin = 3'b010;
    tick();
    sel = '0; coin = '0; cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++; if (credit !== 8'd2 || product !== 4'b0100 || busy !== 1'b0 || coin_reject !== 1'b0) begin
      errors++; $display("FAIL cancel_ignored: credit=%0d product=%b busy=%b reject=%b want 2/0100/0/0", credit, product, busy, coin_reject);
    end
    coin = 3'b010;
    tick();
    coin = 3'b001;
    tick();
    coin = '0;
    checks++; if (credit !== 8'd5) begin errors++; $display("FAIL cancel_off_credit: got %0d want 5", credit); end
    tick();
    checks++; if (deliver !== 1'b1) begin errors++; $display("FAIL cancel_off_deliver: got %b want 1", deliver); end
    tick();
    checks++; if (credit !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL cancel_off_idle: credit=%0d busy=%b want 0/0", credit, busy); end
`endif
  endtask

  task automatic test_reset_mid_change();
    sel = 4'b0001; coin = 3'b100;
    tick();
    sel = '0; coin = '0;
    tick();
    tick();
    checks++; if (credit !== 8'd3 || change_coin !== 3'b010 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_enter: credit=%0d change_coin=%b busy=%b want 3/010/1", credit, change_coin, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++; if (credit !== 8'd0 || change_coin !== 3'b000 || busy !== 1'b0 || product !== 4'b0000) begin
      errors++; $display("FAIL mid_reset: credit=%0d change_coin=%b busy=%b product=%b want 0/000/0/0000",
                         credit, change_coin, busy, product);
    end
    reset = 1'b1;
    tick();
    checks++; if (credit !== 8'd0 || change_coin !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_no_refund: credit=%0d change_coin=%b busy=%b want 0/000/0", credit, change_coin, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vend_reject();
    test_change();
    test_bad_coin();
    test_max_credit();
    test_cancel();
    test_reset_mid_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
